// File: rtl/car_pkg.sv
// Package: car_pkg
// Purpose: shared definitions for the ignition sequencer.
//   - state encoding reported on the dashboard state bus
//   - fault-cause codes
//   - war_vec bit positions and the default critical-warning mask
//   - actuator decode helper used for the registered Moore outputs
package car_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PRECHECK = 3'd1,
    ST_CRANK    = 3'd2,
    ST_RUN      = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAULT    = 3'd5,
    ST_LOCKOUT  = 3'd6
  } state_e;

  localparam logic [1:0] FC_NONE          = 2'd0;
  localparam logic [1:0] FC_PRECHECK_DROP = 2'd1;
  localparam logic [1:0] FC_CRIT_RUN      = 2'd2;
  localparam logic [1:0] FC_LOCKOUT       = 2'd3;

  // war_vec bit positions, MSB first
  localparam int WAR_ENGINEOIL      = 8;
  localparam int WAR_BATTERYVOLTAGE = 7;
  localparam int WAR_OILPRESSURE    = 6;
  localparam int WAR_FUELLEVEL      = 5;
  localparam int WAR_WATERLEVEL     = 4;
  localparam int WAR_TYREPRESSURE   = 3;
  localparam int WAR_SEATBELT       = 2;
  localparam int WAR_AIRBAG         = 1;
  localparam int WAR_ENGINETEMP     = 0;

  // engineoil | oilpressure | enginetemp
  localparam logic [8:0] CRIT_MASK_DEFAULT = 9'h141;

  // {ign_on, fuel_pump, starter_on} for a given state
  function automatic logic [2:0] actuators(input state_e s);
    logic [2:0] a;
    a = 3'b000;
    case (s)
      ST_PRECHECK: a = 3'b110;
      ST_CRANK:    a = 3'b111;
      ST_RUN:      a = 3'b110;
      ST_COOLDOWN: a = 3'b100;
      default:     a = 3'b000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Module: cycle_timer
// Purpose: down-counter shared by the timed sequencer states. A load arms it
//   with N; done pulses during the Nth cycle after the load edge, so the
//   owning state lasts exactly N cycles when it leaves on done.
// Ports:
//   clk       in  1  system clock
//   rst_n     in  1  asynchronous active-low reset
//   load      in  1  arm the timer (wins over counting)
//   load_val  in  8  cycle count to arm with (0 is not a legal value)
//   done      out 1  single-cycle expiry pulse
module cycle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // Counter parks at 0 after the final cycle, so this is a one-cycle pulse.
  assign done = (r_cnt == 8'd1);

endmodule

// File: rtl/ignition_sequencer.sv
// Module: ignition_sequencer
// Purpose: timed engine start sequence OFF -> PRECHECK -> CRANK -> RUN with
//   bounded crank retries, cooldown between attempts, fault latching and
//   lockout. All inputs are registered once; outputs are registered Moore
//   outputs decoded from the next state, giving a two-edge input-to-output
//   response.
// Ports:
//   clk           in  1  system clock
//   rst_n         in  1  asynchronous active-low reset
//   key           in  1  PIN-accepted flag
//   readytogo     in  1  all-checks-pass flag
//   war_vec       in  9  warning flags (bit map in car_pkg)
//   start_req     in  1  start button, level
//   stop_req      in  1  stop / fault-acknowledge button, level
//   engine_fired  in  1  rpm-above-idle flag
//   ign_on        out 1  ignition relay
//   fuel_pump     out 1  fuel pump enable
//   starter_on    out 1  starter motor
//   state         out 3  current state (car_pkg::state_e encoding)
//   retry_cnt     out 3  failed crank attempts so far
//   fault_code    out 2  fault cause (car_pkg FC_* codes)
//   fault_war     out 9  war_vec snapshot taken on fault entry
module ignition_sequencer
  import car_pkg::*;
#(
  parameter int unsigned PRECHECK_CYC  = 4,
  parameter int unsigned CRANK_MAX_CYC = 16,
  parameter int unsigned COOL_CYC      = 8,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter logic [8:0]  CRIT_MASK     = CRIT_MASK_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  input  logic       readytogo,
  input  logic [8:0] war_vec,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       engine_fired,
  output logic       ign_on,
  output logic       fuel_pump,
  output logic       starter_on,
  output logic [2:0] state,
  output logic [2:0] retry_cnt,
  output logic [1:0] fault_code,
  output logic [8:0] fault_war
);

  // Registered input copies
  logic       r_key;
  logic       r_ready;
  logic       r_start;
  logic       r_stop;
  logic       r_fired;
  logic [8:0] r_war;

  // Sequencer state
  state_e     r_state;
  logic [2:0] r_retry;
  logic [1:0] r_fcode;
  logic [8:0] r_fwar;
  logic       r_ign;
  logic       r_fuel;
  logic       r_starter;

  // Next-state logic
  state_e     w_state_next;
  logic [2:0] w_retry_next;
  logic [1:0] w_fcode_next;
  logic [8:0] w_fwar_next;
  logic [2:0] w_retry_inc;
  logic       w_abort;
  logic       w_tmr_load;
  logic [7:0] w_tmr_val;
  logic       w_tmr_done;

  cycle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .done     (w_tmr_done)
  );

  assign w_abort     = r_stop | ~r_key;
  assign w_retry_inc = r_retry + 3'd1;

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_fcode_next = r_fcode;
    w_fwar_next  = r_fwar;
    w_tmr_load   = 1'b0;
    w_tmr_val    = 8'(PRECHECK_CYC);

    case (r_state)
      ST_OFF: begin
        if (r_start && r_key) begin
          w_state_next = ST_PRECHECK;
          w_tmr_load   = 1'b1;
          w_tmr_val    = 8'(PRECHECK_CYC);
        end
      end

      // Abort is tested first in every active state so it beats fault/fire.
      ST_PRECHECK: begin
        if (w_abort) begin
          w_state_next = ST_OFF;
          w_retry_next = 3'd0;
        end else if (!r_ready) begin
          w_state_next = ST_FAULT;
          w_fcode_next = FC_PRECHECK_DROP;
          w_fwar_next  = r_war;
        end else if (w_tmr_done) begin
          w_state_next = ST_CRANK;
          w_tmr_load   = 1'b1;
          w_tmr_val    = 8'(CRANK_MAX_CYC);
        end
      end

      ST_CRANK: begin
        if (w_abort) begin
          w_state_next = ST_OFF;
          w_retry_next = 3'd0;
        end else if (r_fired) begin
          // Fire is checked before expiry so a last-cycle fire still counts.
          w_state_next = ST_RUN;
          w_retry_next = 3'd0;
        end else if (w_tmr_done) begin
          w_retry_next = w_retry_inc;
          if (w_retry_inc == 3'(MAX_RETRIES)) begin
            w_state_next = ST_LOCKOUT;
            w_fcode_next = FC_LOCKOUT;
          end else begin
            w_state_next = ST_COOLDOWN;
            w_tmr_load   = 1'b1;
            w_tmr_val    = 8'(COOL_CYC);
          end
        end
      end

      ST_COOLDOWN: begin
        if (w_abort) begin
          w_state_next = ST_OFF;
          w_retry_next = 3'd0;
        end else if (w_tmr_done) begin
          w_state_next = ST_PRECHECK;
          w_tmr_load   = 1'b1;
          w_tmr_val    = 8'(PRECHECK_CYC);
        end
      end

      ST_RUN: begin
        if (w_abort) begin
          w_state_next = ST_OFF;
          w_retry_next = 3'd0;
        end else if ((r_war & CRIT_MASK) != 9'd0) begin
          w_state_next = ST_FAULT;
          w_fcode_next = FC_CRIT_RUN;
          w_fwar_next  = r_war;
        end
      end

      ST_FAULT: begin
        if (r_stop) begin
          w_state_next = ST_OFF;
          w_retry_next = 3'd0;
          w_fcode_next = FC_NONE;
          w_fwar_next  = 9'd0;
        end
      end

      ST_LOCKOUT: begin
        // Needs the key out as well, so a stuck stop button cannot unlock.
        if (!r_key && r_stop) begin
          w_state_next = ST_OFF;
          w_retry_next = 3'd0;
          w_fcode_next = FC_NONE;
        end
      end

      default: begin
        w_state_next = ST_OFF;
        w_retry_next = 3'd0;
        w_fcode_next = FC_NONE;
        w_fwar_next  = 9'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key     <= 1'b0;
      r_ready   <= 1'b0;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_fired   <= 1'b0;
      r_war     <= 9'd0;
      r_state   <= ST_OFF;
      r_retry   <= 3'd0;
      r_fcode   <= FC_NONE;
      r_fwar    <= 9'd0;
      r_ign     <= 1'b0;
      r_fuel    <= 1'b0;
      r_starter <= 1'b0;
    end else begin
      r_key     <= key;
      r_ready   <= readytogo;
      r_start   <= start_req;
      r_stop    <= stop_req;
      r_fired   <= engine_fired;
      r_war     <= war_vec;
      r_state   <= w_state_next;
      r_retry   <= w_retry_next;
      r_fcode   <= w_fcode_next;
      r_fwar    <= w_fwar_next;
      // Decoding the next state keeps actuators aligned with r_state
      // while still coming straight from flops.
      {r_ign, r_fuel, r_starter} <= actuators(w_state_next);
    end
  end

  assign ign_on     = r_ign;
  assign fuel_pump  = r_fuel;
  assign starter_on = r_starter;
  assign state      = r_state;
  assign retry_cnt  = r_retry;
  assign fault_code = r_fcode;
  assign fault_war  = r_fwar;

endmodule

// File: tb/tb_ignition_sequencer.sv
// Testbench: tb_ignition_sequencer
// Directed scenarios for the ignition sequencer with hand-computed expected
// values: nominal start, retry/lockout, precheck drop, RUN faults, priority
// cases and asynchronous reset.
module tb_ignition_sequencer;

  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_PRECHECK = 3'd1;
  localparam logic [2:0] S_CRANK    = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;
  localparam logic [2:0] S_LOCKOUT  = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic       readytogo;
  logic [8:0] war_vec;
  logic       start_req;
  logic       stop_req;
  logic       engine_fired;
  logic       ign_on;
  logic       fuel_pump;
  logic       starter_on;
  logic [2:0] state;
  logic [2:0] retry_cnt;
  logic [1:0] fault_code;
  logic [8:0] fault_war;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  ignition_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .readytogo    (readytogo),
    .war_vec      (war_vec),
    .start_req    (start_req),
    .stop_req     (stop_req),
    .engine_fired (engine_fired),
    .ign_on       (ign_on),
    .fuel_pump    (fuel_pump),
    .starter_on   (starter_on),
    .state        (state),
    .retry_cnt    (retry_cnt),
    .fault_code   (fault_code),
    .fault_war    (fault_war)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Step until state==s (bounded); reaching it is itself a comparison.
  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int k;
    k = 0;
    while (state !== s && k < budget) begin
      tick();
      k++;
    end
    check_val(tag, 32'(state), 32'(s));
  endtask

  // Count consecutive samples spent in state s, leaving on the first other one.
  task automatic measure(input logic [2:0] s, output int len);
    len = 0;
    while (state === s && len < 200) begin
      len++;
      tick();
    end
  endtask

  task automatic pulse_start;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  task automatic stop_to_off(input string tag);
    stop_req = 1'b1;
    tick();
    tick();
    check_val(tag, 32'(state), 32'(S_OFF));
    stop_req = 1'b0;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    key          = 1'b0;
    readytogo    = 1'b0;
    war_vec      = 9'd0;
    start_req    = 1'b0;
    stop_req     = 1'b0;
    engine_fired = 1'b0;
    tick();
    tick();
    check_val("rst_state", 32'(state), 32'(S_OFF));
    check_val("rst_outs", 32'({ign_on, fuel_pump, starter_on, retry_cnt, fault_code, fault_war}), 32'd0);
    rst_n     = 1'b1;
    key       = 1'b1;
    readytogo = 1'b1;
    tick();

    // 1. Nominal start, fire on 3rd CRANK cycle
    pulse_start();
    wait_state(S_PRECHECK, 10, "t1_reach_pre");
    measure(S_PRECHECK, n);
    check_val("t1_pre_len", 32'(n), 32'd4);
    check_val("t1_starter", 32'(starter_on), 32'd1);
    tick();
    engine_fired = 1'b1;
    measure(S_CRANK, n);
    check_val("t1_crank_len", 32'(n + 1), 32'd3);
    check_val("t1_run", 32'(state), 32'(S_RUN));
    check_val("t1_act", 32'({ign_on, fuel_pump, starter_on}), 32'b110);
    check_val("t1_retry", 32'(retry_cnt), 32'd0);
    engine_fired = 1'b0;
    stop_to_off("t1_off");

    // 2. Retries to LOCKOUT
    pulse_start();
    wait_state(S_CRANK, 20, "t2_reach_crank");
    for (int a = 0; a < 3; a++) begin
      measure(S_CRANK, n);
      check_val("t2_crank_len", 32'(n), 32'd16);
      if (a < 2) begin
        check_val("t2_cool_state", 32'(state), 32'(S_COOLDOWN));
        check_val("t2_cool_retry", 32'(retry_cnt), 32'(a + 1));
        check_val("t2_cool_act", 32'({ign_on, fuel_pump, starter_on}), 32'b100);
        measure(S_COOLDOWN, n);
        check_val("t2_cool_len", 32'(n), 32'd8);
        measure(S_PRECHECK, n);
        check_val("t2_pre_len", 32'(n), 32'd4);
      end
    end
    check_val("t2_lockout", 32'(state), 32'(S_LOCKOUT));
    check_val("t2_fcode", 32'(fault_code), 32'd3);
    check_val("t2_retry", 32'(retry_cnt), 32'd3);
    check_val("t2_act", 32'({ign_on, fuel_pump, starter_on}), 32'd0);
    stop_req = 1'b1;
    repeat (3) tick();
    check_val("t2_stop_key1", 32'(state), 32'(S_LOCKOUT));
    key = 1'b0;
    tick();
    tick();
    check_val("t2_unlock", 32'(state), 32'(S_OFF));
    check_val("t2_unlock_clr", 32'({retry_cnt, fault_code}), 32'd0);
    stop_req = 1'b0;
    key      = 1'b1;
    tick();
    tick();

    // 3. readytogo drops on 2nd PRECHECK cycle
    war_vec = 9'h004;
    pulse_start();
    wait_state(S_PRECHECK, 10, "t3_reach_pre");
    readytogo = 1'b0;
    tick();
    check_val("t3_still_pre", 32'(state), 32'(S_PRECHECK));
    tick();
    check_val("t3_fault", 32'(state), 32'(S_FAULT));
    check_val("t3_fcode", 32'(fault_code), 32'd1);
    check_val("t3_fwar", 32'(fault_war), 32'h004);
    check_val("t3_act", 32'({ign_on, fuel_pump, starter_on}), 32'd0);
    readytogo = 1'b1;
    war_vec   = 9'd0;
    repeat (3) tick();
    check_val("t3_hold", 32'({state, fault_code, fault_war}), 32'({S_FAULT, 2'd1, 9'h004}));
    stop_to_off("t3_off");
    check_val("t3_clr", 32'({fault_code, fault_war}), 32'd0);

    // 4. RUN: non-critical ignored, critical faults
    pulse_start();
    wait_state(S_CRANK, 20, "t4_reach_crank");
    engine_fired = 1'b1;
    wait_state(S_RUN, 5, "t4_reach_run");
    engine_fired = 1'b0;
    war_vec = 9'h010;
    repeat (4) tick();
    check_val("t4_noncrit", 32'(state), 32'(S_RUN));
    war_vec = 9'h001;
    tick();
    tick();
    check_val("t4_crit", 32'(state), 32'(S_FAULT));
    check_val("t4_fcode", 32'(fault_code), 32'd2);
    check_val("t4_fwar", 32'(fault_war), 32'h001);
    war_vec = 9'd0;
    stop_to_off("t4_off");

    // 5a. stop and fire together in CRANK
    pulse_start();
    wait_state(S_CRANK, 20, "t5a_reach_crank");
    stop_req     = 1'b1;
    engine_fired = 1'b1;
    tick();
    tick();
    check_val("t5a_abort", 32'(state), 32'(S_OFF));
    stop_req     = 1'b0;
    engine_fired = 1'b0;
    tick();

    // 5b. fire in the 16th (expiry) CRANK cycle
    pulse_start();
    wait_state(S_CRANK, 20, "t5b_reach_crank");
    repeat (14) tick();
    engine_fired = 1'b1;
    tick();
    check_val("t5b_crank16", 32'({state, starter_on}), 32'({S_CRANK, 1'b1}));
    tick();
    check_val("t5b_run", 32'(state), 32'(S_RUN));
    check_val("t5b_retry", 32'(retry_cnt), 32'd0);
    engine_fired = 1'b0;
    stop_to_off("t5b_off");

    // 5c. key drop in COOLDOWN
    pulse_start();
    wait_state(S_COOLDOWN, 40, "t5c_reach_cool");
    check_val("t5c_retry1", 32'(retry_cnt), 32'd1);
    key = 1'b0;
    tick();
    tick();
    check_val("t5c_off", 32'(state), 32'(S_OFF));
    check_val("t5c_retry0", 32'(retry_cnt), 32'd0);
    key = 1'b1;
    tick();

    // 6. async reset mid-CRANK
    pulse_start();
    wait_state(S_CRANK, 20, "t6_reach_crank");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_act", 32'({ign_on, fuel_pump, starter_on}), 32'd0);
    check_val("t6_async_state", 32'(state), 32'(S_OFF));
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_val("t6_after", 32'({state, starter_on}), 32'({S_OFF, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
